// File: rtl/gpo_pkg.sv
// Shared types and helpers for the GPO pad-bank controller.
package gpo_pkg;

  typedef enum logic [1:0] {
    ModePp   = 2'b00,
    ModeOd   = 2'b01,
    ModeOs   = 2'b10,
    ModeRsvd = 2'b11
  } gpo_mode_e;

  typedef enum logic [1:0] {
    BiasOff  = 2'b00,
    BiasWait = 2'b01,
    BiasOn   = 2'b10,
    BiasLost = 2'b11
  } bias_st_e;

  typedef struct packed {
    logic      oe;
    logic [1:0] ds;
    logic      sr;
    gpo_mode_e mode;
  } gpo_cfg_t;

  localparam gpo_cfg_t CfgReset = '{oe: 1'b0, ds: 2'b00, sr: 1'b0, mode: ModePp};

  function automatic logic needs_bias(input gpo_cfg_t c);
    return c.oe && (c.ds != 2'b00);
  endfunction

  // Changing drive or mode on a live pad must go through break-before-make.
  function automatic logic needs_bbm(input gpo_cfg_t cur, input gpo_cfg_t nxt);
    return cur.oe && ((cur.ds != nxt.ds) || (cur.mode != nxt.mode));
  endfunction

endpackage

// File: rtl/gpo_bias_fsm.sv
// VBIAS sequencer: synchronises BIAS_OK, enforces a settle time, and reports bias loss.
module gpo_bias_fsm
  import gpo_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_need,
  input  logic       i_bias_ok,
  output logic       o_bias_on,
  output logic       o_bias_lost,
  output logic       o_bias_req,
  output logic [1:0] o_bias_st
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

  logic             r_sync1, r_sync2;
  bias_st_e         r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_bias_req;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (!i_need) begin
      w_state_d = BiasOff;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        BiasOff: begin
          w_state_d = BiasWait;
          w_cnt_d   = '0;
        end
        BiasWait: begin
          if (!r_sync2) begin
            w_cnt_d = '0;
          end else if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
            w_state_d = BiasOn;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
        BiasOn: begin
          if (!r_sync2) w_state_d = BiasLost;
        end
        BiasLost: begin
          if (r_sync2) begin
            w_state_d = BiasWait;
            w_cnt_d   = '0;
          end
        end
        default: w_state_d = BiasOff;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_state    <= BiasOff;
      r_cnt      <= '0;
      r_bias_req <= 1'b0;
    end else begin
      r_sync1    <= i_bias_ok;
      r_sync2    <= r_sync1;
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_bias_req <= (w_state_d != BiasOff);
    end
  end

  // Look-ahead so the drive drop lands on the same edge as the state change.
  assign o_bias_on   = (w_state_d == BiasOn);
  assign o_bias_lost = (r_state == BiasOn) && i_need && !r_sync2;
  assign o_bias_req  = r_bias_req;
  assign o_bias_st   = r_state;

endmodule

// File: rtl/gpo_bank_ctrl.sv
// Config engine and registered pad controls for a bank of GPO pad cells.
module gpo_bank_ctrl
  import gpo_pkg::*;
#(
  parameter  int unsigned N_CH       = 8,
  parameter  int unsigned SETTLE_CYC = 64,
  parameter  int unsigned BBM_CYC    = 2,
  localparam int unsigned IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  // One spare bit so out-of-range channel requests are representable.
  localparam int unsigned CH_W       = IDX_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic              i_cfg_oe,
  input  logic [1:0]        i_cfg_ds,
  input  logic              i_cfg_sr,
  input  logic [1:0]        i_cfg_mode,
  input  logic [N_CH-1:0]   i_data,
  input  logic              i_bias_ok,
  output logic              o_bias_req,
  input  logic              i_err_clr,
  output logic [N_CH-1:0]   o_do,
  output logic [N_CH-1:0]   o_oe,
  output logic [N_CH-1:0]   o_sr,
  output logic [N_CH-1:0]   o_odp,
  output logic [N_CH-1:0]   o_odn,
  output logic [2*N_CH-1:0] o_ds,
  output logic [1:0]        o_bias_st,
  output logic [1:0]        o_err
);

  localparam int unsigned BBM_W = $clog2(BBM_CYC + 1);

  gpo_cfg_t         r_cfg [N_CH];
  gpo_cfg_t         w_cfg_d [N_CH];
  gpo_cfg_t         w_new;
  logic [BBM_W-1:0] r_bbm_cnt, w_bbm_cnt_d;
  logic [IDX_W-1:0] r_bbm_ch, w_bbm_ch_d;
  logic [IDX_W-1:0] w_idx;
  logic             w_fire, w_ch_ok, w_bbm_active;
  logic             w_need, w_bias_on, w_bias_lost;
  logic             r_ready;
  logic [1:0]       r_err, w_err_d;

  logic [N_CH-1:0]   r_do, r_oe, r_sr, r_odp, r_odn;
  logic [2*N_CH-1:0] r_ds;

  assign w_fire  = i_cfg_valid && r_ready;
  assign w_ch_ok = (i_cfg_ch < CH_W'(N_CH));
  assign w_idx   = i_cfg_ch[IDX_W-1:0];

  always_comb begin
    w_new.oe   = i_cfg_oe;
    w_new.ds   = i_cfg_ds;
    w_new.sr   = i_cfg_sr;
    w_new.mode = gpo_mode_e'(i_cfg_mode);
  end

  always_comb begin
    w_need = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_need = w_need | needs_bias(r_cfg[c]);
    end
  end

  gpo_bias_fsm #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_bias_fsm (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_need     (w_need),
    .i_bias_ok  (i_bias_ok),
    .o_bias_on  (w_bias_on),
    .o_bias_lost(w_bias_lost),
    .o_bias_req (o_bias_req),
    .o_bias_st  (o_bias_st)
  );

  always_comb begin
    w_cfg_d     = r_cfg;
    w_bbm_ch_d  = r_bbm_ch;
    w_bbm_cnt_d = (r_bbm_cnt != '0) ? (r_bbm_cnt - BBM_W'(1)) : '0;
    if (w_fire && w_ch_ok) begin
      w_cfg_d[w_idx] = w_new;
      if (needs_bbm(r_cfg[w_idx], w_new)) begin
        w_bbm_cnt_d = BBM_W'(BBM_CYC);
        w_bbm_ch_d  = w_idx;
      end
    end
    // Set events win over a simultaneous clear.
    w_err_d[0] = w_bias_lost || (r_err[0] && !i_err_clr);
    w_err_d[1] = (w_fire && !w_ch_ok) || (r_err[1] && !i_err_clr);
  end

  assign w_bbm_active = (w_bbm_cnt_d != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cfg     <= '{default: CfgReset};
      r_bbm_cnt <= '0;
      r_bbm_ch  <= '0;
      r_ready   <= 1'b0;
      r_err     <= 2'b00;
      r_do      <= '0;
      r_oe      <= '0;
      r_sr      <= '0;
      r_odp     <= '0;
      r_odn     <= '0;
      r_ds      <= '0;
    end else begin
      r_cfg     <= w_cfg_d;
      r_bbm_cnt <= w_bbm_cnt_d;
      r_bbm_ch  <= w_bbm_ch_d;
      r_ready   <= !w_bbm_active;
      r_err     <= w_err_d;
      r_do      <= i_data;
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_oe[c]       <= w_cfg_d[c].oe && (w_cfg_d[c].mode != ModeRsvd) &&
                         !(w_bbm_active && (w_bbm_ch_d == IDX_W'(c)));
        r_sr[c]       <= w_cfg_d[c].sr;
        r_odn[c]      <= (w_cfg_d[c].mode == ModeOd);
        r_odp[c]      <= (w_cfg_d[c].mode == ModeOs);
        r_ds[2*c +: 2] <= w_bias_on ? w_cfg_d[c].ds : 2'b00;
      end
    end
  end

  assign o_cfg_ready = r_ready;
  assign o_err       = r_err;
  assign o_do        = r_do;
  assign o_oe        = r_oe;
  assign o_sr        = r_sr;
  assign o_odp       = r_odp;
  assign o_odn       = r_odn;
  assign o_ds        = r_ds;

endmodule

// File: tb/tb_gpo_bank_ctrl.sv
// Scoreboard bench for gpo_bank_ctrl: expectations queued at drive time, popped after the edge.
module tb_gpo_bank_ctrl;

  localparam int unsigned NCh    = 8;
  localparam int unsigned Settle = 64;
  localparam int unsigned Bbm    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid, cfg_ready;
  logic [3:0]        cfg_ch;
  logic              cfg_oe, cfg_sr;
  logic [1:0]        cfg_ds, cfg_mode;
  logic [NCh-1:0]    data;
  logic              bias_ok, bias_req, err_clr;
  logic [NCh-1:0]    o_do, o_oe, o_sr, o_odp, o_odn;
  logic [2*NCh-1:0]  o_ds;
  logic [1:0]        bias_st, err;

  always #5 clk = ~clk;

  gpo_bank_ctrl #(
    .N_CH      (NCh),
    .SETTLE_CYC(Settle),
    .BBM_CYC   (Bbm)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cfg_valid(cfg_valid),
    .o_cfg_ready(cfg_ready),
    .i_cfg_ch   (cfg_ch),
    .i_cfg_oe   (cfg_oe),
    .i_cfg_ds   (cfg_ds),
    .i_cfg_sr   (cfg_sr),
    .i_cfg_mode (cfg_mode),
    .i_data     (data),
    .i_bias_ok  (bias_ok),
    .o_bias_req (bias_req),
    .i_err_clr  (err_clr),
    .o_do       (o_do),
    .o_oe       (o_oe),
    .o_sr       (o_sr),
    .o_odp      (o_odp),
    .o_odn      (o_odn),
    .o_ds       (o_ds),
    .o_bias_st  (bias_st),
    .o_err      (err)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  string       sb_tag[$];
  logic [31:0] sb_exp[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (sb_exp.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_underflow: got 0x%0h with no expectation queued", obs);
    end else begin
      check_eq(sb_tag.pop_front(), obs, sb_exp.pop_front());
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One valid cycle; the engine must be ready when a request is issued.
  task automatic cfg(input logic [3:0] ch, input logic oe, input logic [1:0] ds,
                     input logic sr, input logic [1:0] mode);
    check_eq("cfg_ready_pre", {31'd0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_oe    = oe;
    cfg_ds    = ds;
    cfg_sr    = sr;
    cfg_mode  = mode;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NCh-1:0] d;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_oe = 1'b0; cfg_ds = '0;
    cfg_sr = 1'b0; cfg_mode = '0; data = 8'hA5; bias_ok = 1'b1; err_clr = 1'b0;

    // Reset state
    tick(3);
    sb_push("rst_oe", 0); sb_push("rst_ds", 0); sb_push("rst_st", 0);
    sb_push("rst_rdy", 0); sb_push("rst_req", 0); sb_push("rst_err", 0); sb_push("rst_do", 0);
    sb_pop(o_oe); sb_pop(o_ds); sb_pop(bias_st);
    sb_pop(cfg_ready); sb_pop(bias_req); sb_pop(err); sb_pop(o_do);
    rst = 1'b0;
    sb_push("rdy_after_rst", 1); sb_push("do_first", 8'hA5);
    tick();
    sb_pop(cfg_ready); sb_pop(o_do);

    // Data path: one-cycle delay
    for (int i = 0; i < 6; i++) begin
      d = NCh'($urandom);
      data = d;
      sb_push("do_delay", d);
      tick();
      sb_pop(o_do);
    end

    // Elevated drive on ch2 waits for bias settle
    sb_push("t2_oe", 8'h04); sb_push("t2_ds_gated", 0); sb_push("t2_req_lag", 0);
    cfg(4'd2, 1'b1, 2'b11, 1'b0, 2'b00);
    sb_pop(o_oe); sb_pop(o_ds); sb_pop(bias_req);
    sb_push("t2_req", 1); sb_push("t2_st_wait", 1);
    tick();
    sb_pop(bias_req); sb_pop(bias_st);
    tick(Settle - 1);
    sb_push("t2_ds_still0", 0); sb_push("t2_st_still_wait", 1);
    sb_pop(o_ds[5:4]); sb_pop(bias_st);
    tick();
    sb_push("t2_ds_on", 3); sb_push("t2_st_on", 2);
    sb_pop(o_ds[5:4]); sb_pop(bias_st);

    // Bias loss: visible after the synchroniser plus one edge
    bias_ok = 1'b0;
    tick(2);
    sb_push("t3_st_hold", 2); sb_push("t3_ds_hold", 3);
    sb_pop(bias_st); sb_pop(o_ds[5:4]);
    tick();
    sb_push("t3_st_lost", 3); sb_push("t3_ds_drop", 0); sb_push("t3_err", 1); sb_push("t3_oe", 8'h04);
    sb_pop(bias_st); sb_pop(o_ds); sb_pop(err); sb_pop(o_oe);
    bias_ok = 1'b1;
    tick(2);
    sb_push("t3_st_still_lost", 3);
    sb_pop(bias_st);
    tick();
    sb_push("t3_st_rewait", 1);
    sb_pop(bias_st);
    tick(Settle - 1);
    sb_push("t3_st_rewait_end", 1);
    sb_pop(bias_st);
    tick();
    sb_push("t3_st_reon", 2); sb_push("t3_ds_reon", 3); sb_push("t3_err_sticky", 1);
    sb_pop(bias_st); sb_pop(o_ds[5:4]); sb_pop(err);
    err_clr = 1'b1;
    sb_push("t3_err_clr", 0);
    tick();
    sb_pop(err);
    err_clr = 1'b0;

    // Break-before-make on ch2 mode change, ch5 must be untouched
    sb_push("t4_ch5_on", 8'h24);
    cfg(4'd5, 1'b1, 2'b00, 1'b0, 2'b00);
    sb_pop(o_oe);
    sb_push("t4_oe_w1", 8'h20); sb_push("t4_rdy_w1", 0); sb_push("t4_odn_w1", 8'h04);
    sb_push("t4_ds_w1", 3);
    cfg(4'd2, 1'b1, 2'b11, 1'b0, 2'b01);
    sb_pop(o_oe); sb_pop(cfg_ready); sb_pop(o_odn); sb_pop(o_ds[5:4]);
    sb_push("t4_oe_w2", 8'h20); sb_push("t4_rdy_w2", 0);
    tick();
    sb_pop(o_oe); sb_pop(cfg_ready);
    sb_push("t4_oe_back", 8'h24); sb_push("t4_rdy_back", 1); sb_push("t4_odn", 8'h04);
    tick();
    sb_pop(o_oe); sb_pop(cfg_ready); sb_pop(o_odn);

    // SR-only change on a live pad skips BBM
    sb_push("sr_oe", 8'h24); sb_push("sr_rdy", 1); sb_push("sr_val", 8'h04);
    cfg(4'd2, 1'b1, 2'b11, 1'b1, 2'b01);
    sb_pop(o_oe); sb_pop(cfg_ready); sb_pop(o_sr);

    // Mode decode: reserved mode blocks OE, open-source raises ODP
    sb_push("rsvd_oe", 8'h24); sb_push("rsvd_odp", 0); sb_push("rsvd_odn", 8'h04);
    cfg(4'd6, 1'b1, 2'b00, 1'b0, 2'b11);
    sb_pop(o_oe); sb_pop(o_odp); sb_pop(o_odn);
    sb_push("os_oe", 8'hA4); sb_push("os_odp", 8'h80);
    cfg(4'd7, 1'b1, 2'b00, 1'b0, 2'b10);
    sb_pop(o_oe); sb_pop(o_odp);

    // Out-of-range channel
    sb_push("bad_err", 2); sb_push("bad_oe", 8'hA4); sb_push("bad_ds", 16'h0030);
    sb_push("bad_rdy", 1);
    cfg(4'd9, 1'b1, 2'b11, 1'b0, 2'b00);
    sb_pop(err); sb_pop(o_oe); sb_pop(o_ds); sb_pop(cfg_ready);
    err_clr = 1'b1;
    sb_push("bad_clr", 0);
    tick();
    sb_pop(err);
    sb_push("bad_set_wins", 2);
    cfg(4'd9, 1'b0, 2'b00, 1'b0, 2'b00);
    sb_pop(err);
    err_clr = 1'b0;
    sb_push("bad_hold", 2);
    tick();
    sb_pop(err);

    // Reset during a BBM window discards the pending config
    sb_push("t6_ch0_on", 8'hA5);
    cfg(4'd0, 1'b1, 2'b00, 1'b0, 2'b00);
    sb_pop(o_oe);
    sb_push("t6_bbm_oe", 8'hA4); sb_push("t6_bbm_rdy", 0);
    cfg(4'd0, 1'b1, 2'b01, 1'b0, 2'b00);
    sb_pop(o_oe); sb_pop(cfg_ready);
    rst = 1'b1;
    sb_push("t6_oe", 0); sb_push("t6_ds", 0); sb_push("t6_st", 0); sb_push("t6_rdy", 0);
    sb_push("t6_err", 0); sb_push("t6_req", 0); sb_push("t6_odn_odp_sr", 0);
    tick();
    sb_pop(o_oe); sb_pop(o_ds); sb_pop(bias_st); sb_pop(cfg_ready);
    sb_pop(err); sb_pop(bias_req); sb_pop({o_odn, o_odp, o_sr});
    rst = 1'b0;
    sb_push("t6_rdy_rel", 1); sb_push("t6_oe_rel", 0);
    tick();
    sb_pop(cfg_ready); sb_pop(o_oe);
    tick(3);
    sb_push("t6_oe_late", 0); sb_push("t6_ds_late", 0); sb_push("t6_st_late", 0);
    sb_pop(o_oe); sb_pop(o_ds); sb_pop(bias_st);

    if (sb_exp.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d expectations never compared", sb_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
